bcd_universal_counter: RTL and testbench

BCD_UNIVERSAL_COUNTER -- requirements
Module: bcd_universal_counter

---
 rtl/bcd_universal_counter.sv | 127 ++++++++++++
 tb/tb_bcd_universal_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_universal_counter.sv
// bcd_universal_counter: multi-digit BCD up/down counter with synchronous clear,
// validated parallel load, wrap-or-saturate limit handling and limit flags.
//
// Parameters
//   DIGITS   number of BCD digits (legal range 1..8)
//   WRAP     1 = wrap at the limits, 0 = saturate at the limits
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   syn_clr   synchronous clear (highest priority)
//   load      synchronous load of d (ignored if any digit of d is > 9)
//   en        count enable, one step per enabled cycle
//   up        direction: 1 = increment, 0 = decrement
//   d         BCD load value, digit 0 in bits [3:0]
//   q         registered BCD count
//   max_tick  combinational: every digit of q is 9
//   min_tick  combinational: q is zero
//   ovf       registered one-cycle pulse on an increment/decrement at a limit
//   load_err  registered one-cycle pulse on a rejected load
module bcd_universal_counter #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                syn_clr,
  input  logic                load,
  input  logic                en,
  input  logic                up,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                max_tick,
  output logic                min_tick,
  output logic                ovf,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] q_q, q_d;
  logic         ovf_q, ovf_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] inc_val, dec_val;
  logic         inc_carry, dec_borrow, d_ok;

  // Ripple decimal increment/decrement across all digits in one cycle.
  // A carry/borrow leaving the top digit marks a limit crossing; in that case
  // inc_val/dec_val already hold the wrapped value (0 or all 9s).
  always_comb begin
    inc_val    = q_q;
    dec_val    = q_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    d_ok       = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
      if (d[4*i +: 4] > 4'd9) begin
        d_ok = 1'b0;
      end
    end
  end

  // Next-state selection: clear > load > count > hold.
  always_comb begin
    q_d        = q_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    if (syn_clr) begin
      q_d = '0;
    end else if (load) begin
      if (d_ok) begin
        q_d = d;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        ovf_d = inc_carry;
        if (!(inc_carry && !WRAP)) begin
          q_d = inc_val;
        end
      end else begin
        ovf_d = dec_borrow;
        if (!(dec_borrow && !WRAP)) begin
          q_d = dec_val;
        end
      end
    end
  end

  // State and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q        <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;
  assign max_tick = (q_q == ALL_NINES);
  assign min_tick = (q_q == '0);

endmodule

// File: tb/tb_bcd_universal_counter.sv
// Testbench for bcd_universal_counter: one wrapping and one saturating instance
// (DIGITS=4) driven by the same inputs, checked by a directed vector table,
// hand-written reset sequences and randomized stimulus against an integer model.
module tb_bcd_universal_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         reset, syn_clr, load, en, up;
  logic [W-1:0] d;
  logic [W-1:0] q_w, q_s;
  logic         max_w, min_w, ovf_w, err_w;
  logic         max_s, min_s, ovf_s, err_s;

  int n_checks = 0;
  int n_errors = 0;
  int mw = 0;  // model value of the wrapping instance (0..9999)
  int ms = 0;  // model value of the saturating instance

  always #5 clk = ~clk;

  bcd_universal_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q_w), .max_tick(max_w), .min_tick(min_w), .ovf(ovf_w), .load_err(err_w)
  );

  bcd_universal_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q_s), .max_tick(max_s), .min_tick(min_s), .ovf(ovf_s), .load_err(err_s)
  );

  typedef struct {
    logic         clr, ld, en, up;
    logic [W-1:0] d;
    logic [W-1:0] qw;
    logic         ow;
    logic [W-1:0] qs;
    logic         os;
    logic         err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic c, input logic l, input logic e, input logic u,
                              input logic [W-1:0] dv, input logic [W-1:0] qw, input logic ow,
                              input logic [W-1:0] qs, input logic os, input logic er);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.up = u; v.d = dv;
    v.qw = qw; v.ow = ow; v.qs = qs; v.os = os; v.err = er;
    return v;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < int'(DIGITS); i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b);
    int v = 0, p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      v += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] b = '0;
    int r = x;
    for (int i = 0; i < int'(DIGITS); i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  // Behavioural model: counts in plain integers over 0..9999.
  task automatic model(input int v, input bit wrap, input logic c, input logic l,
                       input logic e, input logic u, input logic [W-1:0] dv,
                       output int nv, output bit o, output bit er);
    nv = v; o = 1'b0; er = 1'b0;
    if (c) nv = 0;
    else if (l) begin
      if (bcd_ok(dv)) nv = bcd2int(dv);
      else er = 1'b1;
    end else if (e) begin
      if (u) begin
        if (v == 9999) begin o = 1'b1; nv = wrap ? 0 : 9999; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin o = 1'b1; nv = wrap ? 9999 : 0; end
        else nv = v - 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic c, input logic l, input logic e, input logic u,
                       input logic [W-1:0] dv);
    syn_clr = c; load = l; en = e; up = u; d = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input bit ow, input bit os,
                             input bit ew, input bit es);
    chk({tag, "/q_w"}, 32'(q_w), 32'(int2bcd(mw)));
    chk({tag, "/q_s"}, 32'(q_s), 32'(int2bcd(ms)));
    chk({tag, "/ovf_w"}, 32'(ovf_w), 32'(ow));
    chk({tag, "/ovf_s"}, 32'(ovf_s), 32'(os));
    chk({tag, "/err_w"}, 32'(err_w), 32'(ew));
    chk({tag, "/err_s"}, 32'(err_s), 32'(es));
    chk({tag, "/max_w"}, 32'(max_w), 32'(mw == 9999));
    chk({tag, "/min_w"}, 32'(min_w), 32'(mw == 0));
    chk({tag, "/max_s"}, 32'(max_s), 32'(ms == 9999));
    chk({tag, "/min_s"}, 32'(min_s), 32'(ms == 0));
  endtask

  task automatic rstep(input logic c, input logic l, input logic e, input logic u,
                       input logic [W-1:0] dv, input string tag);
    int nw, ns;
    bit ow, os, ew, es;
    model(mw, 1'b1, c, l, e, u, dv, nw, ow, ew);
    model(ms, 1'b0, c, l, e, u, dv, ns, os, es);
    apply(c, l, e, u, dv);
    mw = nw; ms = ns;
    check_model(tag, ow, os, ew, es);
  endtask

  // Pulse reset low between clock edges and check the asynchronous response.
  task automatic reset_pulse(input string tag);
    syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    mw = 0; ms = 0;
    check_model(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    //              clr ld en up d         qw        ow   qs        os   err
    vecs[0]  = mk(0, 1, 0, 0, 16'h0999, 16'h0999, 0, 16'h0999, 0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 16'h0000, 16'h1000, 0, 16'h1000, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 16'h9999, 16'h9999, 0, 16'h9999, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1, 16'h0000, 16'h0000, 1, 16'h9999, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h9999, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 16'h0000, 16'h9999, 1, 16'h0000, 1, 0);
    vecs[7]  = mk(0, 0, 1, 0, 16'h0000, 16'h9998, 0, 16'h0000, 1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 16'h0000, 16'h9997, 0, 16'h0000, 1, 0);
    vecs[9]  = mk(0, 1, 1, 0, 16'h12A4, 16'h9997, 0, 16'h0000, 0, 1);
    vecs[10] = mk(0, 1, 0, 0, 16'h0042, 16'h0042, 0, 16'h0042, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 16'h0500, 16'h0500, 0, 16'h0500, 0, 0);
    vecs[12] = mk(1, 1, 1, 1, 16'h0700, 16'h0000, 0, 16'h0000, 0, 0);
    vecs[13] = mk(0, 1, 1, 1, 16'h0300, 16'h0300, 0, 16'h0300, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 16'h0000, 16'h0301, 0, 16'h0301, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 16'h9990, 16'h9990, 0, 16'h9990, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 16'h0000, 16'h9991, 0, 16'h9991, 0, 0);
    vecs[17] = mk(0, 1, 0, 1, 16'h00F0, 16'h9991, 0, 16'h9991, 0, 1);
    vecs[18] = mk(0, 0, 1, 0, 16'h0000, 16'h9990, 0, 16'h9990, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 16'h0000, 16'h9990, 0, 16'h9990, 0, 0);

    reset = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;
    #2;
    check_model("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset = 1'b1;

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].d);
      chk({tag, "/q_w"}, 32'(q_w), 32'(vecs[i].qw));
      chk({tag, "/q_s"}, 32'(q_s), 32'(vecs[i].qs));
      chk({tag, "/ovf_w"}, 32'(ovf_w), 32'(vecs[i].ow));
      chk({tag, "/ovf_s"}, 32'(ovf_s), 32'(vecs[i].os));
      chk({tag, "/err_w"}, 32'(err_w), 32'(vecs[i].err));
      chk({tag, "/err_s"}, 32'(err_s), 32'(vecs[i].err));
      chk({tag, "/max_w"}, 32'(max_w), 32'(vecs[i].qw == 16'h9999));
      chk({tag, "/min_w"}, 32'(min_w), 32'(vecs[i].qw == 16'h0000));
      chk({tag, "/max_s"}, 32'(max_s), 32'(vecs[i].qs == 16'h9999));
      chk({tag, "/min_s"}, 32'(min_s), 32'(vecs[i].qs == 16'h0000));
    end
    mw = bcd2int(vecs[NVEC-1].qw);
    ms = bcd2int(vecs[NVEC-1].qs);

    // Reset mid-count: count to 0357, reset between edges, resume from zero.
    rstep(0, 1, 0, 0, 16'h0350, "ld0350");
    for (int i = 0; i < 7; i++) rstep(0, 0, 1, 1, 16'h0000, "cnt");
    chk("q_at_0357", 32'(q_w), 32'h0357);
    reset_pulse("rst_mid");
    rstep(0, 0, 1, 1, 16'h0000, "after_rst");
    chk("q_after_rst", 32'(q_w), 32'h0001);

    // Reset must also kill a pending ovf pulse.
    rstep(0, 1, 0, 0, 16'h9999, "ld9999");
    rstep(0, 0, 1, 1, 16'h0000, "ovf_up");
    reset_pulse("rst_ovf");
    rstep(0, 0, 0, 0, 16'h0000, "hold0");

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      logic c, l, e, u;
      logic [W-1:0] dv;
      int k;
      c = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 9);
      case (k)
        0:       dv = 16'h9999;
        1:       dv = 16'h0000;
        2:       dv = 16'($urandom);
        3:       dv = 16'h9998;
        4:       dv = 16'h0001;
        default: dv = int2bcd($urandom_range(0, 9999));
      endcase
      rstep(c, l, e, u, dv, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
